// File: rtl/dram_bridge_mc_if.sv
// AXI4-Lite master bundle between the multi-channel DRAM bridge and the DRAM model.
interface dram_bridge_mc_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 17
);
  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;

  modport master (
    output AR_VALID, AR_ADDR, input AR_READY,
    input  R_VALID, R_DATA, R_RESP, output R_READY,
    output AW_VALID, AW_ADDR, input AW_READY,
    output W_VALID, W_DATA, input W_READY,
    input  B_VALID, B_RESP, output B_READY
  );

  modport slave (
    input  AR_VALID, AR_ADDR, output AR_READY,
    output R_VALID, R_DATA, R_RESP, input R_READY,
    input  AW_VALID, AW_ADDR, output AW_READY,
    input  W_VALID, W_DATA, output W_READY,
    output B_VALID, B_RESP, input B_READY
  );
endinterface

// File: rtl/dram_bridge_mc.sv
// Multi-channel client-to-DRAM bridge: per-channel request capture, round-robin
// arbitration, one outstanding AXI4-Lite transaction, completion/error pulses.
module dram_bridge_mc #(
  parameter int              NUM_CH    = 2,
  parameter int              IDX_W     = 8,
  parameter int              DATA_W    = 64,
  parameter int              ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000,
  parameter int              STRIDE_SH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        C_in_valid,
  input  logic [NUM_CH-1:0]        C_r_wb,
  input  logic [NUM_CH*IDX_W-1:0]  C_addr,
  input  logic [NUM_CH*DATA_W-1:0] C_data_w,
  output logic [NUM_CH-1:0]        C_out_valid,
  output logic [NUM_CH-1:0]        C_err,
  output logic [DATA_W-1:0]        C_data_r,
  dram_bridge_mc_if.master         axi
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic                ar_valid_q, ar_valid_d;
  logic                r_ready_q, r_ready_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                b_ready_q, b_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_r_q, data_r_d;
  logic                err_q, err_d;

  logic [NUM_CH-1:0]   cap, cand, done_clr;
  logic [IDX_W-1:0]    c_idx [NUM_CH];
  logic [DATA_W-1:0]   c_data [NUM_CH];
  logic                slot_rwb_q [NUM_CH];
  logic [IDX_W-1:0]    slot_idx_q [NUM_CH];
  logic [DATA_W-1:0]   slot_data_q [NUM_CH];

  logic [CH_W:0]       pick;
  logic [CH_W-1:0]     win;
  logic                win_rwb;
  logic [IDX_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(idx);
    off = off << STRIDE_SH;
    return BASE_ADDR + off;
  endfunction

  // Search starts at the channel after the last grant and wraps once.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] c,
                                            input logic [CH_W-1:0]   last);
    logic [NUM_CH-1:0] sh;
    int                k;
    rr_pick = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      k = int'(last) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      sh = c >> k;
      if (!rr_pick[CH_W] && sh[0]) rr_pick = {1'b1, CH_W'(k)};
    end
  endfunction

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    assign c_idx[g]       = C_addr[g*IDX_W +: IDX_W];
    assign c_data[g]      = C_data_w[g*DATA_W +: DATA_W];
    assign done_clr[g]    = (state_q == DONE) && (grant_q == CH_W'(g));
    // A completing channel may accept its next request in the same cycle.
    assign cap[g]         = C_in_valid[g] & (~pend_q[g] | done_clr[g]);
    assign C_out_valid[g] = done_clr[g];
    assign C_err[g]       = done_clr[g] & err_q;

    always_ff @(posedge clk) begin
      if (cap[g]) begin
        slot_rwb_q[g]  <= C_r_wb[g];
        slot_idx_q[g]  <= c_idx[g];
        slot_data_q[g] <= c_data[g];
      end
    end
  end

  assign cand     = pend_q | C_in_valid;
  assign pick     = rr_pick(cand, rr_q);
  assign win      = pick[CH_W-1:0];
  assign win_rwb  = pend_q[win] ? slot_rwb_q[win]  : C_r_wb[win];
  assign win_idx  = pend_q[win] ? slot_idx_q[win]  : c_idx[win];
  assign win_data = pend_q[win] ? slot_data_q[win] : c_data[win];
  assign pend_d   = (pend_q & ~done_clr) | cap;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_r_d   = data_r_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick[CH_W]) begin
          grant_d = win;
          addr_d  = map_addr(win_idx);
          if (win_rwb) begin
            ar_valid_d = 1'b1;
            state_d    = RD_A;
          end else begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            wdata_d    = win_data;
            state_d    = WR_AW;
          end
        end
      end
      RD_A: begin
        if (axi.AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_D;
        end
      end
      RD_D: begin
        if (axi.R_VALID) begin
          data_r_d  = axi.R_DATA;
          err_d     = (axi.R_RESP != 2'b00);
          r_ready_d = 1'b0;
          state_d   = DONE;
        end
      end
      WR_AW: begin
        // Address and data channels complete independently, in either order.
        aw_valid_d = aw_valid_q & ~axi.AW_READY;
        w_valid_d  = w_valid_q & ~axi.W_READY;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (axi.B_VALID) begin
          err_d     = (axi.B_RESP != 2'b00);
          data_r_d  = '0;
          b_ready_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        rr_d    = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      pend_q     <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_r_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_r_q   <= data_r_d;
      err_q      <= err_d;
    end
  end

  assign axi.AR_VALID = ar_valid_q;
  assign axi.AR_ADDR  = addr_q;
  assign axi.R_READY  = r_ready_q;
  assign axi.AW_VALID = aw_valid_q;
  assign axi.AW_ADDR  = addr_q;
  assign axi.W_VALID  = w_valid_q;
  assign axi.W_DATA   = wdata_q;
  assign axi.B_READY  = b_ready_q;
  assign C_data_r     = data_r_q;
endmodule

// File: tb/tb_dram_bridge_mc.sv
// Scoreboard bench for dram_bridge_mc: directed client requests, a reactive AXI
// slave model, and a monitor comparing each completion pulse against the queue.
module tb_dram_bridge_mc;
  localparam int NUM_CH = 2;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 17;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        C_in_valid = '0;
  logic [NUM_CH-1:0]        C_r_wb = '0;
  logic [NUM_CH*IDX_W-1:0]  C_addr = '0;
  logic [NUM_CH*DATA_W-1:0] C_data_w = '0;
  logic [NUM_CH-1:0]        C_out_valid;
  logic [NUM_CH-1:0]        C_err;
  logic [DATA_W-1:0]        C_data_r;

  dram_bridge_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

  dram_bridge_mc #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(17'h10000), .STRIDE_SH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_err(C_err), .C_data_r(C_data_r),
    .axi(axi.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    bit                rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] rmem [logic [ADDR_W-1:0]];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                out_cnt0 = 0;
  int                out_cnt1 = 0;
  int                aw_dly = 0;
  int                w_dly  = 0;
  logic [1:0]        rresp_cfg = 2'b00;
  logic [1:0]        bresp_cfg = 2'b00;
  bit                r_stall = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [7:0] idx);
    return 17'h10000 + {6'b0, idx, 3'b000};
  endfunction

  function automatic void push(input int ch, input bit rw, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                               input bit err);
    exp_q.push_back('{ch, rw, a, wd, rd, err});
  endfunction

  task automatic req(input int ch, input bit rw, input logic [7:0] idx,
                     input logic [DATA_W-1:0] d);
    C_r_wb[ch]               = rw;
    C_addr[ch*IDX_W +: IDX_W] = idx;
    C_data_w[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic fire(input logic [NUM_CH-1:0] m);
    C_in_valid = m;
    @(negedge clk);
    C_in_valid = '0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every completion pulse pops one expected transaction.
  always @(negedge clk) begin
    if (rst_n && (C_out_valid != '0 || C_err != '0)) begin
      if (C_out_valid[0]) out_cnt0++;
      if (C_out_valid[1]) out_cnt1++;
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 64'(C_out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid", 64'(C_out_valid), 64'd1 << e.ch);
        check("err", 64'(C_err), e.err ? (64'd1 << e.ch) : 64'd0);
        check("data_r", C_data_r, e.rw ? e.rdata : 64'd0);
        check("axi_addr", 64'(last_addr), 64'(e.addr));
        if (!e.rw) check("w_data", last_wdata, e.wdata);
      end
    end
  end

  // Reactive DRAM-side slave model.
  initial begin
    bit ok;
    bit aw_done;
    bit w_done;
    axi.AR_READY = 1'b0; axi.R_VALID = 1'b0; axi.R_DATA = '0; axi.R_RESP = 2'b00;
    axi.AW_READY = 1'b0; axi.W_READY = 1'b0; axi.B_VALID = 1'b0; axi.B_RESP = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n && axi.AR_VALID) begin
        axi.AR_READY = 1'b1;
        last_addr = axi.AR_ADDR;
        @(negedge clk);
        axi.AR_READY = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
          if (!rst_n) break;
          if (axi.R_READY && !r_stall) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        if (ok) begin
          axi.R_VALID = 1'b1;
          axi.R_DATA  = rmem.exists(last_addr) ? rmem[last_addr] : 64'h0;
          axi.R_RESP  = rresp_cfg;
          @(negedge clk);
          axi.R_VALID = 1'b0; axi.R_DATA = '0; axi.R_RESP = 2'b00;
        end else if (rst_n) begin
          fail_now("r_ready_wait");
        end
      end else if (rst_n && axi.AW_VALID) begin
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int n = 0; n < 100 && !(aw_done && w_done) && rst_n; n++) begin
          if (aw_done && !w_done) begin
            check("aw_dropped", 64'(axi.AW_VALID), 64'd0);
            check("w_held", 64'(axi.W_VALID), 64'd1);
            check("b_ready_early", 64'(axi.B_READY), 64'd0);
          end
          axi.AW_READY = !aw_done && (n >= aw_dly);
          axi.W_READY  = !w_done && (n >= w_dly);
          if (axi.AW_READY) last_addr = axi.AW_ADDR;
          if (axi.W_READY)  last_wdata = axi.W_DATA;
          @(negedge clk);
          if (axi.AW_READY) aw_done = 1'b1;
          if (axi.W_READY)  w_done = 1'b1;
          axi.AW_READY = 1'b0;
          axi.W_READY  = 1'b0;
        end
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
          if (!rst_n) break;
          if (axi.B_READY) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        if (ok) begin
          axi.B_VALID = 1'b1;
          axi.B_RESP  = bresp_cfg;
          @(negedge clk);
          axi.B_VALID = 1'b0; axi.B_RESP = 2'b00;
        end else if (rst_n) begin
          fail_now("b_ready_wait");
        end
      end
    end
  end

  initial begin
    int snap0;
    int snap1;
    bit seen;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] v1;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_client", {60'd0, C_out_valid, C_err}, 64'd0);
    check("rst_data_r", C_data_r, 64'd0);
    check("rst_axi_ctl", 64'({axi.AR_VALID, axi.R_READY, axi.AW_VALID, axi.W_VALID, axi.B_READY}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read on ch0
    rmem[17'h10028] = 64'hDEAD_BEEF_0123_4567;
    push(0, 1'b1, 17'h10028, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    req(0, 1'b1, 8'h05, 64'd0);
    fire(2'b01);
    drain();

    // Single write on ch1, data channel ready three cycles after address
    aw_dly = 0; w_dly = 3;
    push(1, 1'b0, 17'h107F8, 64'h1, 64'd0, 1'b0);
    req(1, 1'b0, 8'hFF, 64'h1);
    fire(2'b10);
    drain();
    w_dly = 0;

    // Simultaneous requests on both channels, four rounds
    for (int r = 0; r < 4; r++) begin
      i0 = 8'h10 + 8'(r);
      i1 = 8'h20 + 8'(r);
      v0 = 64'hA5A5_0000_0000_0000 | (64'(r) << 8);
      v1 = 64'h5A5A_0000_0000_0001 | (64'(r) << 8);
      rmem[exp_addr(i0)] = v0;
      rmem[exp_addr(i1)] = v1;
      push(0, 1'b1, exp_addr(i0), 64'd0, v0, 1'b0);
      push(1, 1'b1, exp_addr(i1), 64'd0, v1, 1'b0);
      req(0, 1'b1, i0, 64'd0);
      req(1, 1'b1, i1, 64'd0);
      fire(2'b11);
      drain();
    end

    // Error responses on read and write, then a clean read
    rresp_cfg = 2'b10;
    rmem[exp_addr(8'h30)] = 64'h1111_2222_3333_4444;
    push(0, 1'b1, exp_addr(8'h30), 64'd0, 64'h1111_2222_3333_4444, 1'b1);
    req(0, 1'b1, 8'h30, 64'd0);
    fire(2'b01);
    drain();
    rresp_cfg = 2'b00;
    rmem[exp_addr(8'h31)] = 64'h5555_6666_7777_8888;
    push(0, 1'b1, exp_addr(8'h31), 64'd0, 64'h5555_6666_7777_8888, 1'b0);
    req(0, 1'b1, 8'h31, 64'd0);
    fire(2'b01);
    drain();
    bresp_cfg = 2'b11;
    push(1, 1'b0, exp_addr(8'h40), 64'hCAFE_F00D_0000_0042, 64'd0, 1'b1);
    req(1, 1'b0, 8'h40, 64'hCAFE_F00D_0000_0042);
    fire(2'b10);
    drain();
    bresp_cfg = 2'b00;

    // Re-request on ch0 during its own completion cycle
    snap0 = out_cnt0;
    rmem[exp_addr(8'h50)] = 64'h0000_0000_0000_0050;
    rmem[exp_addr(8'h51)] = 64'h0000_0000_0000_0051;
    push(0, 1'b1, exp_addr(8'h50), 64'd0, 64'h50, 1'b0);
    req(0, 1'b1, 8'h50, 64'd0);
    fire(2'b01);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (C_out_valid[0]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) fail_now("done_wait");
    push(0, 1'b1, exp_addr(8'h51), 64'd0, 64'h51, 1'b0);
    req(0, 1'b1, 8'h51, 64'd0);
    fire(2'b01);
    drain();
    check("re_req_count", 64'(out_cnt0 - snap0), 64'd2);

    // Reset while waiting for read data
    r_stall = 1'b1;
    req(0, 1'b1, 8'h60, 64'd0);
    fire(2'b01);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (axi.R_READY) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) fail_now("rd_d_wait");
    rst_n = 1'b0;
    #1;
    check("midrst_client", {60'd0, C_out_valid, C_err}, 64'd0);
    check("midrst_data_r", C_data_r, 64'd0);
    check("midrst_axi_ctl", 64'({axi.AR_VALID, axi.R_READY, axi.AW_VALID, axi.W_VALID, axi.B_READY}), 64'd0);
    check("midrst_addr", 64'(axi.AR_ADDR), 64'd0);
    repeat (2) @(negedge clk);
    r_stall = 1'b0;
    rst_n = 1'b1;
    snap0 = out_cnt0;
    snap1 = out_cnt1;
    repeat (6) @(negedge clk);
    check("postrst_idle", 64'({axi.AR_VALID, axi.AW_VALID}), 64'd0);
    check("postrst_no_pulse", 64'((out_cnt0 - snap0) + (out_cnt1 - snap1)), 64'd0);

    // Recovery: bridge serves a fresh request after reset
    rmem[exp_addr(8'h70)] = 64'h7070_7070_7070_7070;
    push(1, 1'b1, exp_addr(8'h70), 64'd0, 64'h7070_7070_7070_7070, 1'b0);
    req(1, 1'b1, 8'h70, 64'd0);
    fire(2'b10);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_bridge_mc.md
Name: dram_bridge_mc

Overview:
- Parametrised successor to the single-client FD-to-DRAM bridge.
- Serves NUM_CH client channels over the simple C_* request interface (C_in_valid, C_r_wb, C_addr, C_data_w / C_out_valid, C_data_r).
- Round-robin arbitration between channels onto one AXI4-Lite master port toward the DRAM model.
- Adds per-channel request capture, configurable address mapping, and error reporting from R_RESP/B_RESP.

Parameters:
NUM_CH, 2, number of client channels (1..8)
IDX_W, 8, width of a client index (C_addr)
DATA_W, 64, data width of the client and AXI data buses
ADDR_W, 17, AXI address width
BASE_ADDR, 17'h10000, DRAM byte address of index 0
STRIDE_SH, 3, byte address = BASE_ADDR + (idx << STRIDE_SH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
C_in_valid  in  NUM_CH  per-channel one-cycle request pulse
C_r_wb  in  NUM_CH  per channel: 1 = read, 0 = write
C_addr  in  NUM_CH*IDX_W  per-channel index; channel k uses slice [k*IDX_W +: IDX_W]
C_data_w  in  NUM_CH*DATA_W  per-channel write data
C_out_valid  out  NUM_CH  one-cycle completion pulse to the granted channel
C_err  out  NUM_CH  one-cycle pulse, coincident with C_out_valid, when RESP != 0
C_data_r  out  DATA_W  read data (shared bus); 0 on write completion
AR_VALID  out  1  read address valid
AR_ADDR  out  ADDR_W  read address
AR_READY  in  1  read address ready
R_VALID  in  1  read data valid
R_DATA  in  DATA_W  read data
R_RESP  in  2  read response
R_READY  out  1  read data ready
AW_VALID  out  1  write address valid
AW_ADDR  out  ADDR_W  write address
AW_READY  in  1  write address ready
W_VALID  out  1  write data valid
W_DATA  out  DATA_W  write data
W_READY  in  1  write data ready
B_VALID  in  1  write response valid
B_RESP  in  2  write response
B_READY  out  1  write response ready

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, pending regs cleared, FSM to IDLE, round-robin pointer = 0.
  - Mid-transaction reset aborts the transaction; no completion pulse is issued.
- Capture: on C_in_valid[k], latch r_wb, addr and data into channel k's slot and set pend[k].
  - A pulse on a channel already pending is ignored; the original request is kept.
  - If the pulse arrives in the same cycle that channel's completion clears pend[k], the new request is captured.
- Arbitration, in IDLE only:
  - Candidates are pend | C_in_valid.
  - Round-robin starting from the channel after the last grant.
  - The winner is registered at the next edge.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE -> RD_A (read) or WR_AW (write) on any candidate:
  - AR_VALID, or AW_VALID and W_VALID, go high at the same edge.
  - Address = BASE_ADDR + (idx << STRIDE_SH), truncated to ADDR_W.
  - Request at edge t on an idle bridge gives VALID high after edge t+1.
- RD_A: hold AR_VALID and AR_ADDR stable until AR_READY; then -> RD_D with R_READY = 1.
- RD_D: on R_VALID & R_READY:
  - latch R_DATA into C_data_r;
  - err = (R_RESP != 0);
  - drop R_READY; -> DONE.
- WR_AW: AW_VALID and W_VALID each drop independently on their own READY; W_DATA is held while W_VALID is high.
  - When both handshakes are done (same or different cycles) -> WR_B with B_READY = 1.
- WR_B: on B_VALID: err = (B_RESP != 0), C_data_r = 0, drop B_READY; -> DONE.
- DONE (1 cycle):
  - C_out_valid[g] = 1 and C_err[g] = err;
  - clear pend[g]; update the round-robin pointer to g; -> IDLE.
- C_data_r holds its value until the next completion.
- Only one AXI transaction is outstanding at any time; reads and writes never overlap.
- No timeout: the bridge waits indefinitely on READY/VALID.

Test Plan:
1. Single read: ch0 read idx 8'h05 → AR_ADDR = 17'h10028. Return R_DATA = 64'hDEAD_BEEF_0123_4567, RESP = 0 → C_out_valid = 2'b01, C_data_r equals R_DATA, C_err = 0.
2. Single write, split ready: ch1 write idx 8'hFF, data 64'h1 → AW_ADDR = 17'h107F8. W_READY arrives 3 cycles after AW_READY → B_READY only after both handshakes; C_out_valid = 2'b10, C_data_r = 0.
3. Fairness: ch0 and ch1 pulse in the same cycle, repeated 4 times → grants alternate 0,1,0,1; no transaction lost.
4. Error response: read with R_RESP = 2'b10 → C_out_valid[0] and C_err[0] high in the same cycle; the next read with RESP = 0 → C_err = 0.
5. Re-request during completion: ch0 pulses again in its DONE cycle → second transaction issues; exactly 2 completion pulses on ch0.
6. Reset mid-op: rst_n low while in RD_D → all outputs 0 immediately; after release, no stale C_out_valid and pend = 0.
